// File: rtl/lamp_switch_debounce_pkg.sv
// Shared definitions for the staircase-switch conditioning block:
// channel FSM encodings and clock-derived debounce defaults.
package lamp_switch_debounce_pkg;

    typedef enum logic [1:0] {
        ST0 = 2'd0,
        W1  = 2'd1,
        ST1 = 2'd2,
        W0  = 2'd3
    } db_state_t;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned DEBOUNCE_MS = 10;

    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS);

endpackage

// File: rtl/lamp_switch_debounce_if.sv
// Switch-side bundle: raw contacts in, conditioned levels and diagnostic pulses out.
interface lamp_switch_debounce_if #(
    parameter int N_SW = 3
);
    logic [N_SW-1:0] sw_raw;
    logic [N_SW-1:0] sw_stable;
    logic [N_SW-1:0] sw_toggle;
    logic            any_toggle;
    logic [N_SW-1:0] busy;

    modport master (
        output sw_raw,
        input  sw_stable,
        input  sw_toggle,
        input  any_toggle,
        input  busy
    );

    modport slave (
        input  sw_raw,
        output sw_stable,
        output sw_toggle,
        output any_toggle,
        output busy
    );
endinterface

// File: rtl/lamp_switch_debounce_channel.sv
// One switch channel: input synchroniser followed by a hold-count debounce FSM.
module lamp_switch_debounce_channel
    import lamp_switch_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic toggle,
    output logic accept,
    output logic busy
);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;

    db_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             stable_reg, stable_next;
    logic             toggle_reg, toggle_next;

    assign s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg   <= '0;
            state_reg  <= ST0;
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
            toggle_reg <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[SYNC_STAGES-2:0], raw};
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            stable_reg <= stable_next;
            toggle_reg <= toggle_next;
        end
    end

    // The count restarts on every departure from the stable level, so bounces never accumulate.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        toggle_next = 1'b0;
        case (state_reg)
            ST0: begin
                if (s) begin
                    state_next = W1;
                    cnt_next   = '0;
                end
            end
            W1: begin
                if (!s) begin
                    state_next = ST0;
                end else if (cnt_reg == CNT_TERM) begin
                    state_next  = ST1;
                    stable_next = 1'b1;
                    toggle_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST1: begin
                if (!s) begin
                    state_next = W0;
                    cnt_next   = '0;
                end
            end
            W0: begin
                if (s) begin
                    state_next = ST1;
                end else if (cnt_reg == CNT_TERM) begin
                    state_next  = ST0;
                    stable_next = 1'b0;
                    toggle_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = ST0;
        endcase
    end

    assign stable = stable_reg;
    assign toggle = toggle_reg;
    assign accept = toggle_next;
    assign busy   = (state_reg == W1) || (state_reg == W0);

endmodule

// File: rtl/lamp_switch_debounce.sv
// Conditions the staircase switches feeding S1..S3 of the lamp stage; one
// debounce channel per switch plus a combined change pulse.
module lamp_switch_debounce
    import lamp_switch_debounce_pkg::*;
#(
    parameter int N_SW            = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = int'(DEFAULT_DEBOUNCE_CYCLES),
    parameter int CNT_W           = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    lamp_switch_debounce_if.slave  sw_if
);
    logic [N_SW-1:0] stable_w;
    logic [N_SW-1:0] toggle_w;
    logic [N_SW-1:0] accept_w;
    logic [N_SW-1:0] busy_w;
    logic            any_toggle_reg;

    for (genvar gi = 0; gi < N_SW; gi++) begin : g_ch
        lamp_switch_debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .raw    (sw_if.sw_raw[gi]),
            .stable (stable_w[gi]),
            .toggle (toggle_w[gi]),
            .accept (accept_w[gi]),
            .busy   (busy_w[gi])
        );
    end

    // Registered from the channels' next-toggle terms so it lines up with sw_toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_toggle_reg <= 1'b0;
        end else begin
            any_toggle_reg <= |accept_w;
        end
    end

    assign sw_if.sw_stable  = stable_w;
    assign sw_if.sw_toggle  = toggle_w;
    assign sw_if.busy       = busy_w;
    assign sw_if.any_toggle = any_toggle_reg;

endmodule

// File: tb/tb_lamp_switch_debounce.sv
// Bench for lamp_switch_debounce: directed scenarios plus random switching,
// all cross-checked every cycle against a run-length reference model.
module tb_lamp_switch_debounce;
    localparam int N    = 3;
    localparam int SYNC = 2;
    localparam int D    = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   sb_en    = 1'b0;

    lamp_switch_debounce_if #(.N_SW(N)) sw_if ();

    lamp_switch_debounce #(
        .N_SW            (N),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sw_if (sw_if)
    );

    always #5 clk = ~clk;

    // Reference model: the raw level is delayed by the synchroniser depth, then a
    // level is accepted after D+1 consecutive samples that differ from the current one.
    logic [N-1:0] dq[$];
    logic [N-1:0] m_s;
    logic [N-1:0] m_stable, m_toggle, m_busy;
    logic         m_any;
    int           run[N];

    always @(posedge clk) begin
        if (rst) begin
            dq.delete();
            for (int i = 0; i < SYNC; i++) dq.push_back('0);
            m_stable = '0;
            m_toggle = '0;
            m_any    = 1'b0;
            for (int i = 0; i < N; i++) run[i] = 0;
        end else begin
            dq.push_back(sw_if.sw_raw);
            m_s      = dq.pop_front();
            m_toggle = '0;
            for (int i = 0; i < N; i++) begin
                if (m_s[i] != m_stable[i]) begin
                    run[i]++;
                    if (run[i] == D + 1) begin
                        m_stable[i] = ~m_stable[i];
                        m_toggle[i] = 1'b1;
                        run[i]      = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_any = |m_toggle;
        end
        for (int i = 0; i < N; i++) m_busy[i] = (run[i] != 0);
    end

    // Scoreboard: lamp-stage inputs S1..S3 and diagnostics against the model every cycle.
    always @(negedge clk) begin
        if (sb_en) begin
            n_checks++;
            if (sw_if.sw_stable !== m_stable) begin
                n_fail++;
                $display("FAIL sb_stable t=%0t S1..S3 got %b expected %b", $time, sw_if.sw_stable, m_stable);
            end
            n_checks++;
            if (sw_if.sw_toggle !== m_toggle || sw_if.any_toggle !== m_any) begin
                n_fail++;
                $display("FAIL sb_toggle t=%0t got %b/%b expected %b/%b", $time,
                         sw_if.sw_toggle, sw_if.any_toggle, m_toggle, m_any);
            end
            n_checks++;
            if (sw_if.busy !== m_busy) begin
                n_fail++;
                $display("FAIL sb_busy t=%0t got %b expected %b", $time, sw_if.busy, m_busy);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        sw_if.sw_raw = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_en = 1'b1;
        n_checks++;
        if ({sw_if.sw_stable, sw_if.sw_toggle, sw_if.any_toggle, sw_if.busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got stable=%b toggle=%b any=%b busy=%b expected all 0",
                     sw_if.sw_stable, sw_if.sw_toggle, sw_if.any_toggle, sw_if.busy);
        end
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if ({sw_if.sw_stable, sw_if.sw_toggle, sw_if.any_toggle, sw_if.busy} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d got stable=%b toggle=%b any=%b busy=%b expected all 0",
                         k, sw_if.sw_stable, sw_if.sw_toggle, sw_if.any_toggle, sw_if.busy);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_accept();
        sw_if.sw_raw[0] = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (sw_if.sw_stable[0] !== (k >= SYNC + D + 1) ||
                sw_if.sw_toggle[0] !== (k == SYNC + D + 1) ||
                sw_if.busy[0]      !== (k >= SYNC + 1 && k <= SYNC + D)) begin
                n_fail++;
                $display("FAIL accept_latency edge %0d got stable=%b toggle=%b busy=%b expected %b/%b/%b",
                         k, sw_if.sw_stable[0], sw_if.sw_toggle[0], sw_if.busy[0],
                         k >= SYNC + D + 1, k == SYNC + D + 1, k >= SYNC + 1 && k <= SYNC + D);
            end
        end
        sw_if.sw_raw[0] = 1'b0;
        repeat (14) @(negedge clk);
        n_checks++;
        if (sw_if.sw_stable[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_release got %b expected 0", sw_if.sw_stable[0]);
        end
        $display("test_accept done");
    endtask

    task automatic test_short_pulse();
        sw_if.sw_raw[1] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 5) sw_if.sw_raw[1] = 1'b0;
            n_checks++;
            if (sw_if.sw_stable[1] !== 1'b0 || sw_if.sw_toggle[1] !== 1'b0 ||
                sw_if.busy[1] !== (k >= SYNC + 1 && k <= SYNC + 5)) begin
                n_fail++;
                $display("FAIL short_pulse edge %0d got stable=%b toggle=%b busy=%b expected 0/0/%b",
                         k, sw_if.sw_stable[1], sw_if.sw_toggle[1], sw_if.busy[1],
                         k >= SYNC + 1 && k <= SYNC + 5);
            end
        end
        $display("test_short_pulse done");
    endtask

    task automatic test_bounce_then_hold();
        int toggles = 0;
        for (int b = 0; b < 4; b++) begin
            sw_if.sw_raw[2] = (b % 2 == 0);
            repeat (2) begin
                @(posedge clk); @(negedge clk);
                toggles += int'(sw_if.sw_toggle[2]);
            end
        end
        sw_if.sw_raw[2] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); @(negedge clk);
            toggles += int'(sw_if.sw_toggle[2]);
            if (k == SYNC + D || k == SYNC + D + 1) begin
                n_checks++;
                if (sw_if.sw_stable[2] !== (k == SYNC + D + 1)) begin
                    n_fail++;
                    $display("FAIL bounce_latency edge %0d got %b expected %b",
                             k, sw_if.sw_stable[2], k == SYNC + D + 1);
                end
            end
        end
        n_checks++;
        if (toggles != 1) begin
            n_fail++;
            $display("FAIL bounce_toggle_count got %0d expected 1", toggles);
        end
        sw_if.sw_raw[2] = 1'b0;
        repeat (14) @(negedge clk);
        $display("test_bounce_then_hold done");
    endtask

    task automatic test_all_channels();
        for (int dir = 0; dir < 2; dir++) begin
            logic [N-1:0] lvl;
            lvl = (dir == 0) ? '1 : '0;
            sw_if.sw_raw = lvl;
            for (int k = 1; k <= SYNC + D + 2; k++) begin
                @(posedge clk); @(negedge clk);
                if (k == SYNC + D + 1) begin
                    n_checks++;
                    if (sw_if.sw_stable !== lvl || sw_if.sw_toggle !== '1 || sw_if.any_toggle !== 1'b1) begin
                        n_fail++;
                        $display("FAIL all_accept dir=%0d got stable=%b toggle=%b any=%b expected %b/111/1",
                                 dir, sw_if.sw_stable, sw_if.sw_toggle, sw_if.any_toggle, lvl);
                    end
                end else if (k == SYNC + D + 2) begin
                    n_checks++;
                    if (sw_if.sw_toggle !== '0 || sw_if.any_toggle !== 1'b0) begin
                        n_fail++;
                        $display("FAIL all_pulse_width dir=%0d got toggle=%b any=%b expected 000/0",
                                 dir, sw_if.sw_toggle, sw_if.any_toggle);
                    end
                end
            end
        end
        $display("test_all_channels done");
    endtask

    task automatic test_reset_mid();
        sw_if.sw_raw[0] = 1'b1;
        repeat (SYNC + 6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({sw_if.sw_stable, sw_if.sw_toggle, sw_if.any_toggle, sw_if.busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_clear got stable=%b toggle=%b any=%b busy=%b expected all 0",
                     sw_if.sw_stable, sw_if.sw_toggle, sw_if.any_toggle, sw_if.busy);
        end
        for (int k = 1; k <= SYNC + D + 2; k++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (sw_if.sw_stable[0] !== (k >= SYNC + D + 1) || sw_if.sw_toggle[0] !== (k == SYNC + D + 1)) begin
                n_fail++;
                $display("FAIL reset_mid_requal edge %0d got stable=%b toggle=%b expected %b/%b",
                         k, sw_if.sw_stable[0], sw_if.sw_toggle[0], k >= SYNC + D + 1, k == SYNC + D + 1);
            end
        end
        sw_if.sw_raw[0] = 1'b0;
        repeat (14) @(negedge clk);
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 9) == 0) sw_if.sw_raw[i] = ~sw_if.sw_raw[i];
        end
        sw_if.sw_raw = '0;
        repeat (15) @(negedge clk);
        n_checks++;
        if (sw_if.sw_stable !== '0 || sw_if.busy !== '0) begin
            n_fail++;
            $display("FAIL random_settle got stable=%b busy=%b expected 000/000", sw_if.sw_stable, sw_if.busy);
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_accept();
        test_short_pulse();
        test_bounce_then_hold();
        test_all_channels();
        test_reset_mid();
        test_random();
        sb_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
